// File: rtl/mdio_master.sv
// Clause 22 MDIO management initiator: divides sysclk down to MDC and shifts
// out one 64-bit read or write frame per accepted request.
module mdio_master #(
  parameter int CLK_DIV = 20
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        start,
  input  logic        op_read,
  input  logic [4:0]  phy_addr,
  input  logic [4:0]  reg_addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] rdata,
  output logic        rd_err,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic        mdio_i
);

  localparam int HC_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [HC_W-1:0] HC_MAX = HC_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_HEADER, S_TA, S_DATA, S_DONE
  } state_t;

  state_t          state;
  logic [HC_W-1:0] hc;        // sysclk cycles within the current MDC half-period
  logic [5:0]      bc;        // bit index within the 64-bit frame
  logic            rd_q;      // latched op_read
  logic [31:0]     frame_lo;  // ST, OP, PHYAD, REGAD, TA, DATA (everything after preamble)
  logic [15:0]     shreg;     // read data being shifted in
  logic            mdio_i_p0;
  logic            mdio_i_p1;

  logic accept;
  logic tick;
  logic rise;

  assign accept = start && !busy;
  assign tick   = busy && (hc == HC_MAX);
  assign rise   = tick && !mdc;

  // Frame segment that a given bit index belongs to.
  function automatic state_t phase_of(input logic [5:0] b);
    if (b < 6'd32)      return S_PREAMBLE;
    else if (b < 6'd46) return S_HEADER;
    else if (b < 6'd48) return S_TA;
    else                return S_DATA;
  endfunction

  // Value to present on mdio_o for bit b; released bits of a read idle high.
  function automatic logic bit_value(input logic [5:0] b, input logic rd,
                                     input logic [31:0] lo);
    logic [4:0] idx;
    idx = 5'(6'd63 - b);
    if (b < 6'd32)                 return 1'b1;
    else if (rd && (b >= 6'd46))   return 1'b1;
    else                           return lo[idx];
  endfunction

  // Two-flop synchronizer for the asynchronous PHY data pin.
  always_ff @(posedge sysclk) begin
    mdio_i_p0 <= mdio_i;
    mdio_i_p1 <= mdio_i_p0;
  end

  // Request fields and read shift register; only meaningful while busy.
  always_ff @(posedge sysclk) begin
    if (accept) begin
      rd_q     <= op_read;
      frame_lo <= {2'b01, (op_read ? 2'b10 : 2'b01), phy_addr, reg_addr, 2'b10, wdata};
    end
    if (rise && (bc >= 6'd48)) begin
      shreg <= {shreg[14:0], mdio_i_p1};
    end
  end

  // Frame sequencer: MDC generation, bit stepping and registered pin outputs.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      hc     <= '0;
      bc     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      rdata  <= '0;
      rd_err <= 1'b0;
      mdc    <= 1'b0;
      mdio_o <= 1'b1;
      mdio_t <= 1'b1;
    end else begin
      done <= 1'b0;
      if (accept) begin
        state  <= S_PREAMBLE;
        hc     <= '0;
        bc     <= '0;
        busy   <= 1'b1;
        rd_err <= 1'b0;
        mdc    <= 1'b0;
        mdio_o <= 1'b1;
        mdio_t <= 1'b0;
      end else if (busy) begin
        if (tick) begin
          hc  <= '0;
          mdc <= ~mdc;
          if (!mdc) begin
            // MDC rising: the PHY's data is stable, sample it.
            if (rd_q && (bc == 6'd47)) rd_err <= mdio_i_p1;
          end else if (bc == 6'd63) begin
            state  <= S_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            mdio_o <= 1'b1;
            mdio_t <= 1'b1;
            if (rd_q) rdata <= shreg;
          end else begin
            // MDC falling: next bit period starts, update the pin while MDC is low.
            bc     <= bc + 6'd1;
            state  <= phase_of(bc + 6'd1);
            mdio_o <= bit_value(bc + 6'd1, rd_q, frame_lo);
            mdio_t <= rd_q && ((bc + 6'd1) >= 6'd46);
          end
        end else begin
          hc <= hc + 1'b1;
        end
      end else if (state == S_DONE) begin
        state <= S_IDLE;
      end
    end
  end

endmodule
